pipe_stage_reg: RTL

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush with a configurable bubble value, and saturating stall/flush event counters. It is the general successor to the fixed IF/ID latch. It sits between any two stages of the RV32E core (IF→ID, ID→EX, …) and replaces ad-hoc hazard/flush muxing with backpressure. Payload is opaque; in a PC+instruction stage it carries {pc, inst, imm}.

---
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with a two-entry skid buffer,
// synchronous flush to a bubble value, and saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int unsigned            DATA_W    = 32,
    parameter logic [DATA_W-1:0]      FLUSH_VAL = {DATA_W{1'b0}},
    parameter int unsigned            CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e             state_q,     state_d;
    logic [DATA_W-1:0]  main_q,      main_d;
    logic [DATA_W-1:0]  skid_q,      skid_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic accept_c;
    logic fire_c;
    logic stall_c;
    logic flush_hit_c;

    // Handshake events; in_ready comes straight from a flop, so no out_ready->in_ready path.
    always_comb begin
        accept_c    = in_valid_i & in_ready_q;
        fire_c      = out_valid_q & out_ready_i;
        stall_c     = out_valid_q & ~out_ready_i;
        flush_hit_c = flush_i & ((state_q != ST_EMPTY) | accept_c);
    end

    // Next-state, storage and registered-output computation.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush_i) begin
            // Held and incoming beats are discarded; a concurrent fire already took the old payload.
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept_c && fire_c) begin
                        main_d = in_data_i;
                    end else if (accept_c) begin
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (fire_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (fire_c) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VAL;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_hit_c && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State register; reset dominates flush and handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= FLUSH_VAL;
            skid_q      <= FLUSH_VAL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
